// File: rtl/lut_log_offset_mc_if.sv
// lut_log_offset_mc_if: config, lookup-request and result handshake bundle for lut_log_offset_mc
interface lut_log_offset_mc_if #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 4,
  parameter int OUT_W  = 24
);
  logic                    cfg_we;
  logic [IDX_W-1:0]        cfg_addr;
  logic [OUT_W-1:0]        cfg_wdata;
  logic [IDX_W-1:0]        cfg_max_idx;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_CH*IDX_W-1:0] in_idx;
  logic                    out_valid;
  logic                    out_ready;
  logic [NUM_CH*OUT_W-1:0] out_data;
  modport master (
    output cfg_we, cfg_addr, cfg_wdata, cfg_max_idx, in_valid, in_idx, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, cfg_max_idx, in_valid, in_idx, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lut_log_offset_mc.sv
// lut_log_offset_mc: programmable multi-lane log-offset table with index clamp and 2-stage valid/ready pipe
module lut_log_offset_mc #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 4,
  parameter int OUT_W  = 24
) (
  input logic clk,
  input logic rst,
  lut_log_offset_mc_if.slave bus
);
  localparam int DEPTH = 1 << IDX_W;
  logic [OUT_W-1:0]        tbl [DEPTH];
  logic [IDX_W-1:0]        cidx [NUM_CH];
  logic [IDX_W-1:0]        s1_cidx [NUM_CH];
  logic [NUM_CH*OUT_W-1:0] rd, out_q;
  logic                    s1_v, s2_v, s1_adv, s2_adv;
  always_comb begin
    s2_adv = !s2_v || bus.out_ready;
    s1_adv = !s1_v || s2_adv;
    rd = '0;
    cidx = '{default: '0};
    for (int k = 0; k < NUM_CH; k++) begin
      cidx[k] = bus.in_idx[k*IDX_W +: IDX_W] > bus.cfg_max_idx ? bus.cfg_max_idx : bus.in_idx[k*IDX_W +: IDX_W];
      // a write landing on the same edge as the read is forwarded so the lane never sees stale data
      rd[k*OUT_W +: OUT_W] = bus.cfg_we && bus.cfg_addr == s1_cidx[k] ? bus.cfg_wdata : tbl[s1_cidx[k]];
    end
  end
  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_v;
  assign bus.out_data  = out_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      out_q <= '0;
    end else begin
      if (bus.cfg_we) tbl[bus.cfg_addr] <= bus.cfg_wdata;
      if (s1_adv) s1_v <= bus.in_valid;
      if (s1_adv && bus.in_valid) s1_cidx <= cidx;
      if (s2_adv) s2_v <= s1_v;
      if (s2_adv && s1_v) out_q <= rd;
    end
  end
endmodule

// File: tb/tb_lut_log_offset_mc.sv
// tb_lut_log_offset_mc: scoreboard bench for lut_log_offset_mc covering reset, lookup, clamp, stall, bypass
module tb_lut_log_offset_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [23:0] mtbl [16];
  logic [47:0] q [$];
  lut_log_offset_mc_if bus ();
  lut_log_offset_mc dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [23:0] look(input logic [3:0] i);
    return mtbl[i > bus.cfg_max_idx ? bus.cfg_max_idx : i];
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send_exp(input logic [3:0] a, input logic [3:0] b, input logic [47:0] e);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_idx = {b, a};
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("accept_timeout", 48'd0, 48'd1);
    else q.push_back(e);
    tick;
    bus.in_valid = 1'b0;
  endtask
  task automatic send(input logic [3:0] a, input logic [3:0] b);
    send_exp(a, b, {look(b), look(a)});
  endtask
  task automatic wr(input logic [3:0] a, input logic [23:0] d);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_wdata = d;
    mtbl[a] = d;
    tick;
    bus.cfg_we = 1'b0;
  endtask
  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      tick;
      n++;
    end
    chk("drain", 48'(q.size()), 48'd0);
  endtask
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 48'd1, 48'd0);
      else chk("out_data", bus.out_data, q.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_wdata = '0;
    bus.cfg_max_idx = 4'd15;
    bus.in_valid = 1'b0;
    bus.in_idx = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) mtbl[i] = '0;
    repeat (2) tick;
    @(negedge clk);
    chk("rst_out_valid", 48'(bus.out_valid), 48'd0);
    chk("rst_in_ready", 48'(bus.in_ready), 48'd1);
    chk("rst_out_data", bus.out_data, 48'd0);
    tick;
    rst = 1'b0;
    send(4'd3, 4'd7);
    drain;
    for (int i = 0; i < 16; i++) wr(4'(i), 24'(i) * 24'h010101);
    send(4'd2, 4'd5);
    @(negedge clk);
    chk("lat_n1", 48'(bus.out_valid), 48'd0);
    tick;
    @(negedge clk);
    chk("lat_n2", 48'(bus.out_valid), 48'd1);
    tick;
    @(negedge clk);
    chk("single_pulse", 48'(bus.out_valid), 48'd0);
    tick;
    bus.cfg_max_idx = 4'd12;
    send(4'd15, 4'd4);
    bus.cfg_max_idx = 4'd0;
    drain;
    send(4'd9, 4'd9);
    drain;
    bus.cfg_max_idx = 4'd15;
    bus.out_ready = 1'b0;
    send(4'd1, 4'd1);
    send(4'd2, 4'd2);
    bus.in_valid = 1'b1;
    bus.in_idx = {4'd3, 4'd3};
    repeat (4) begin
      @(negedge clk);
      chk("stall_in_ready", 48'(bus.in_ready), 48'd0);
      chk("stall_out_valid", 48'(bus.out_valid), 48'd1);
      chk("stall_hold", bus.out_data, {24'h010101, 24'h010101});
      tick;
    end
    bus.out_ready = 1'b1;
    send(4'd3, 4'd3);
    @(negedge clk);
    chk("no_gap_2", 48'(bus.out_valid), 48'd1);
    tick;
    @(negedge clk);
    chk("no_gap_3", 48'(bus.out_valid), 48'd1);
    drain;
    send(4'd6, 4'd6);
    send_exp(4'd6, 4'd1, {mtbl[1], 24'hABCDEF});
    wr(4'd6, 24'hABCDEF);
    send(4'd6, 4'd6);
    drain;
    bus.out_ready = 1'b0;
    send(4'd1, 4'd2);
    send(4'd3, 4'd4);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 16; i++) mtbl[i] = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("midrst_out_valid", 48'(bus.out_valid), 48'd0);
    chk("midrst_in_ready", 48'(bus.in_ready), 48'd1);
    send(4'd5, 4'd9);
    drain;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
